// File: rtl/writeback_commit_unit.sv
// Writeback/commit stage: round-robin arbitration over p_num_pipes X__W
// producers into a single-entry W register that drives the register-file
// write port and an in-order commit stream.
module writeback_commit_unit #(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic [p_num_pipes-1:0]                        i_x_val,
  output logic [p_num_pipes-1:0]                        o_x_rdy,
  input  logic [p_num_pipes-1:0][31:0]                  i_x_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]    i_x_seq_num,
  input  logic [p_num_pipes-1:0][4:0]                   i_x_waddr,
  input  logic [p_num_pipes-1:0][31:0]                  i_x_wdata,
  input  logic [p_num_pipes-1:0]                        i_x_wen,
  output logic                                          o_rf_wen,
  output logic [4:0]                                    o_rf_waddr,
  output logic [31:0]                                   o_rf_wdata,
  output logic                                          o_commit_val,
  input  logic                                          i_commit_rdy,
  output logic [31:0]                                   o_commit_pc,
  output logic [p_seq_num_bits-1:0]                     o_commit_seq_num
);

  localparam int unsigned lp_ptr_w = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  // W register and round-robin pointer
  logic                      r_w_val;
  logic [31:0]               r_pc;
  logic [p_seq_num_bits-1:0] r_seq_num;
  logic [4:0]                r_waddr;
  logic [31:0]               r_wdata;
  logic                      r_wen;
  logic [lp_ptr_w-1:0]       r_ptr;

  logic [p_num_pipes-1:0]    w_grant;
  logic [lp_ptr_w-1:0]       w_gidx;
  logic                      w_found;
  logic                      w_space;
  logic                      w_accept;
  logic                      w_commit_fire;
  logic [lp_ptr_w-1:0]       w_ptr_nxt;

  logic [31:0]               w_sel_pc;
  logic [p_seq_num_bits-1:0] w_sel_seq_num;
  logic [4:0]                w_sel_waddr;
  logic [31:0]               w_sel_wdata;
  logic                      w_sel_wen;

  // Round-robin scan starting at r_ptr; first valid pipe wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < int'(p_num_pipes); k++) begin
      for (int i = 0; i < int'(p_num_pipes); i++) begin
        if (!w_found && i_x_val[i] &&
            (((int'(r_ptr) + k) % int'(p_num_pipes)) == i)) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_gidx     = lp_ptr_w'(i);
        end
      end
    end
  end

  // One-hot mux of the granted pipe's message fields.
  always_comb begin
    w_sel_pc      = '0;
    w_sel_seq_num = '0;
    w_sel_waddr   = '0;
    w_sel_wdata   = '0;
    w_sel_wen     = 1'b0;
    for (int i = 0; i < int'(p_num_pipes); i++) begin
      if (w_grant[i]) begin
        w_sel_pc      = i_x_pc[i];
        w_sel_seq_num = i_x_seq_num[i];
        w_sel_waddr   = i_x_waddr[i];
        w_sel_wdata   = i_x_wdata[i];
        w_sel_wen     = i_x_wen[i];
      end
    end
  end

  assign w_commit_fire = r_w_val && i_commit_rdy;
  // W register can take a new result when empty or draining this cycle.
  assign w_space       = !r_w_val || i_commit_rdy;
  assign w_accept      = w_found && w_space;
  assign w_ptr_nxt     = (w_gidx == lp_ptr_w'(p_num_pipes - 1)) ? '0
                                                                : w_gidx + lp_ptr_w'(1);

  assign o_x_rdy = w_grant & {p_num_pipes{w_space}};

  // W register load on accept, drain on commit; async active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_w_val   <= 1'b0;
      r_pc      <= '0;
      r_seq_num <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wen     <= 1'b0;
      r_ptr     <= '0;
    end else if (w_accept) begin
      r_w_val   <= 1'b1;
      r_pc      <= w_sel_pc;
      r_seq_num <= w_sel_seq_num;
      r_waddr   <= w_sel_waddr;
      r_wdata   <= w_sel_wdata;
      r_wen     <= w_sel_wen;
      r_ptr     <= w_ptr_nxt;
    end else if (w_commit_fire) begin
      r_w_val   <= 1'b0;
    end
  end

  // x0 writes are suppressed but the instruction still commits.
  assign o_rf_wen         = w_commit_fire && r_wen && (r_waddr != 5'd0);
  assign o_rf_waddr       = r_waddr;
  assign o_rf_wdata       = r_wdata;
  assign o_commit_val     = r_w_val;
  assign o_commit_pc      = r_pc;
  assign o_commit_seq_num = r_seq_num;

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Scoreboard bench for writeback_commit_unit: stimulus pushes expected
// commits into queues, a negedge monitor pops and compares on commit fire.
module tb_writeback_commit_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  seq;
    logic        rf_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [1:0]      x_val;
  logic [1:0]      x_rdy;
  logic [1:0][31:0] x_pc;
  logic [1:0][4:0] x_seq;
  logic [1:0][4:0] x_waddr;
  logic [1:0][31:0] x_wdata;
  logic [1:0]      x_wen;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            commit_val;
  logic            commit_rdy;
  logic [31:0]     commit_pc;
  logic [4:0]      commit_seq;

  // Per-pipe producer state so each producer process owns its own signals
  logic        p_val[2];
  logic [31:0] p_pc[2];
  logic [4:0]  p_seq[2];
  logic [4:0]  p_waddr[2];
  logic [31:0] p_wdata[2];
  logic        p_wen[2];

  assign x_val   = {p_val[1], p_val[0]};
  assign x_pc    = {p_pc[1], p_pc[0]};
  assign x_seq   = {p_seq[1], p_seq[0]};
  assign x_waddr = {p_waddr[1], p_waddr[0]};
  assign x_wdata = {p_wdata[1], p_wdata[0]};
  assign x_wen   = {p_wen[1], p_wen[0]};

  writeback_commit_unit #(
    .p_num_pipes    (2),
    .p_seq_num_bits (5)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_x_val          (x_val),
    .o_x_rdy          (x_rdy),
    .i_x_pc           (x_pc),
    .i_x_seq_num      (x_seq),
    .i_x_waddr        (x_waddr),
    .i_x_wdata        (x_wdata),
    .i_x_wen          (x_wen),
    .o_rf_wen         (rf_wen),
    .o_rf_waddr       (rf_waddr),
    .o_rf_wdata       (rf_wdata),
    .o_commit_val     (commit_val),
    .i_commit_rdy     (commit_rdy),
    .o_commit_pc      (commit_pc),
    .o_commit_seq_num (commit_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  bit   rand_mode = 1'b0;
  bit   b2b_mode = 1'b0;
  int   b2b_prev = -1;
  exp_t q_dir[$];
  exp_t q_p0[$];
  exp_t q_p1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_exp(input exp_t e);
    chk("commit_pc", commit_pc, e.pc);
    chk("commit_seq_num", 32'(commit_seq), 32'(e.seq));
    chk("rf_wen", 32'(rf_wen), 32'(e.rf_wen));
    chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
    chk("rf_wdata", rf_wdata, e.wdata);
  endtask

  // Monitor: compares every commit fire against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (rf_wen) wr_cnt++;
      if (commit_val && commit_rdy) begin
        if (b2b_mode) begin
          if (b2b_prev >= 0) chk("rr_one_per_cycle", 32'(cyc), 32'(b2b_prev + 1));
          b2b_prev = cyc;
        end
        if (!rand_mode) begin
          if (q_dir.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit actual seq=%0d required none", commit_seq);
          end else cmp_exp(q_dir.pop_front());
        end else if (commit_pc[16] == 1'b0) begin
          if (q_p0.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit_p0 actual seq=%0d required none", commit_seq);
          end else cmp_exp(q_p0.pop_front());
        end else begin
          if (q_p1.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit_p1 actual seq=%0d required none", commit_seq);
          end else cmp_exp(q_p1.pop_front());
        end
      end else begin
        chk("rf_wen_idle", 32'(rf_wen), 32'd0);
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] seq,
                              input logic rfw, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.pc = pc; e.seq = seq; e.rf_wen = rfw; e.waddr = wa; e.wdata = wd;
    return e;
  endfunction

  // Present one message on pipe p (entered just after a posedge) and hold it until accepted.
  task automatic send(input int p, input logic [31:0] pc, input logic [4:0] seq,
                      input logic [4:0] wa, input logic [31:0] wd, input logic we,
                      input int dly);
    logic acc;
    int   n;
    repeat (dly) begin @(posedge clk); #1; end
    p_pc[p] = pc; p_seq[p] = seq; p_waddr[p] = wa; p_wdata[p] = wd; p_wen[p] = we;
    p_val[p] = 1'b1;
    acc = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      acc = x_rdy[p];
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    chk("accept_within_bound", 32'(acc), 32'd1);
    p_val[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_dir.size() + q_p0.size() + q_p1.size()) != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(q_dir.size() + q_p0.size() + q_p1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w0;
    bit   d0, d1;
    rst = 1'b0;
    commit_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p_val[i] = 1'b0; p_pc[i] = '0; p_seq[i] = '0;
      p_waddr[i] = '0; p_wdata[i] = '0; p_wen[i] = 1'b0;
    end

    // Reset state
    #1;
    chk("rst_commit_val", 32'(commit_val), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_commit_seq", 32'(commit_seq), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_x_rdy_none", 32'(x_rdy), 32'd0);
    p_val[1] = 1'b1; #1;
    chk("rst_x_rdy_p1", 32'(x_rdy), 32'd2);
    p_val[0] = 1'b1; #1;
    chk("rst_x_rdy_p0", 32'(x_rdy), 32'd1);
    p_val[0] = 1'b0; p_val[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Round-robin: interleaved 0..5, one commit per cycle
    for (int s = 0; s < 6; s++)
      q_dir.push_back(mk(32'h100 + 32'(s) * 4, 5'(s), 1'b1, 5'(s + 1), 32'(s) * 32'h11));
    b2b_mode = 1'b1; b2b_prev = -1;
    fork
      for (int k = 0; k < 3; k++)
        send(0, 32'h100 + 32'(2 * k) * 4, 5'(2 * k), 5'(2 * k + 1), 32'(2 * k) * 32'h11, 1'b1, 0);
      for (int k = 0; k < 3; k++)
        send(1, 32'h100 + 32'(2 * k + 1) * 4, 5'(2 * k + 1), 5'(2 * k + 2),
             32'(2 * k + 1) * 32'h11, 1'b1, 0);
    join
    drain();
    b2b_mode = 1'b0;

    // Single result with one-cycle latency
    q_dir.push_back(mk(32'h200, 5'd3, 1'b1, 5'd5, 32'hDEADBEEF));
    send(0, 32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1, 0);
    chk("single_commit_val", 32'(commit_val), 32'd1);
    chk("single_rf_wen", 32'(rf_wen), 32'd1);
    drain();

    // x0 write and wen=0 commit without register writes
    w0 = wr_cnt;
    q_dir.push_back(mk(32'h300, 5'd7, 1'b0, 5'd0, 32'd7));
    q_dir.push_back(mk(32'h304, 5'd8, 1'b0, 5'd9, 32'd9));
    send(0, 32'h300, 5'd7, 5'd0, 32'd7, 1'b1, 0);
    send(0, 32'h304, 5'd8, 5'd9, 32'd9, 1'b0, 0);
    drain();
    chk("x0_wen0_no_writes", 32'(wr_cnt - w0), 32'd0);

    // Backpressure: held result stays, all X_rdy low, single write on release
    commit_rdy = 1'b0;
    w0 = wr_cnt;
    q_dir.push_back(mk(32'h400, 5'd6, 1'b1, 5'd3, 32'hCAFE));
    send(1, 32'h400, 5'd6, 5'd3, 32'hCAFE, 1'b1, 0);
    p_pc[0] = 32'h404; p_seq[0] = 5'd9; p_waddr[0] = 5'd4; p_wdata[0] = 32'h99;
    p_wen[0] = 1'b0; p_val[0] = 1'b1;
    q_dir.push_back(mk(32'h404, 5'd9, 1'b0, 5'd4, 32'h99));
    repeat (3) begin
      @(negedge clk);
      chk("bp_commit_val", 32'(commit_val), 32'd1);
      chk("bp_seq_stable", 32'(commit_seq), 32'd6);
      chk("bp_x_rdy_low", 32'(x_rdy), 32'd0);
      chk("bp_rf_wen_low", 32'(rf_wen), 32'd0);
      @(posedge clk); #1;
    end
    commit_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_x_rdy", 32'(x_rdy), 32'd1);
    @(posedge clk); #1;
    p_val[0] = 1'b0;
    chk("bp_one_write", 32'(wr_cnt - w0), 32'd1);
    drain();
    chk("bp_one_write_total", 32'(wr_cnt - w0), 32'd1);

    // Reset mid-operation discards held result and resets the pointer
    commit_rdy = 1'b0;
    send(0, 32'h500, 5'd2, 5'd6, 32'h22, 1'b1, 0);
    chk("mid_held", 32'(commit_val), 32'd1);
    w0 = wr_cnt;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_commit_val", 32'(commit_val), 32'd0);
    chk("mid_rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("mid_rst_seq", 32'(commit_seq), 32'd0);
    @(posedge clk); #1;
    commit_rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    q_dir.push_back(mk(32'h600, 5'd10, 1'b1, 5'd7, 32'hA));
    q_dir.push_back(mk(32'h604, 5'd11, 1'b1, 5'd8, 32'hB));
    fork
      send(0, 32'h600, 5'd10, 5'd7, 32'hA, 1'b1, 0);
      send(1, 32'h604, 5'd11, 5'd8, 32'hB, 1'b1, 0);
      begin
        @(negedge clk);
        chk("mid_post_rst_grant_p0", 32'(x_rdy), 32'd1);
      end
    join
    drain();
    chk("mid_writes", 32'(wr_cnt - w0), 32'd2);

    // Random delays on both producers and the consumer
    rand_mode = 1'b1;
    d0 = 1'b0; d1 = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic [31:0] wd;
          logic        we;
          wd = $urandom;
          we = (k % 3) != 0;
          q_p0.push_back(mk(32'h800 + 32'(k) * 4, 5'(12 + 2 * k), we, 5'(k + 1), wd));
          send(0, 32'h800 + 32'(k) * 4, 5'(12 + 2 * k), 5'(k + 1), wd, we,
               int'($urandom_range(0, 3)));
        end
        d0 = 1'b1;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          logic [31:0] wd;
          logic [4:0]  wa;
          logic        we;
          wd = $urandom;
          wa = (k == 4) ? 5'd0 : 5'(k + 11);
          we = (k % 2) == 0;
          q_p1.push_back(mk(32'h10800 + 32'(k) * 4, 5'(13 + 2 * k), we && (wa != 5'd0), wa, wd));
          send(1, 32'h10800 + 32'(k) * 4, 5'(13 + 2 * k), wa, wd, we,
               int'($urandom_range(0, 3)));
        end
        d1 = 1'b1;
      end
      begin
        int n;
        while (!(d0 && d1)) begin
          commit_rdy = ($urandom_range(0, 1) == 1);
          n = int'($urandom_range(0, 3));
          repeat (n + 1) begin @(posedge clk); #1; end
        end
        commit_rdy = 1'b1;
      end
    join
    drain();
    rand_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_commit_unit.md
# writeback_commit_unit

Writeback/commit stage at the far end of the X__W interface. It accepts completed results from `p_num_pipes` execute units (ALU, multiplier, ...) over valid/ready handshakes and arbitrates among them round-robin. The winner is held in a single-entry W register. The unit then drives the register-file write port and a commit stream carrying `pc` and `seq_num` for in-order tracking and line tracing.

## Interface
- `p_num_pipes`, default 2, number of X__W producers (≥2).
- `p_seq_num_bits`, default 5, width of `seq_num`.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `X_val`  in  `[p_num_pipes]`  per-pipe message valid.
- `X_rdy`  out  `[p_num_pipes]`  per-pipe accept.
- `X_pc`  in  `[p_num_pipes][32]`  instruction pc.
- `X_seq_num`  in  `[p_num_pipes][p_seq_num_bits]`  sequence number.
- `X_waddr`  in  `[p_num_pipes][5]`  destination register.
- `X_wdata`  in  `[p_num_pipes][32]`  result.
- `X_wen`  in  `[p_num_pipes]`  instruction writes a register.
- `rf_wen`  out  1  register-file write strobe.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `commit_val`  out  1  W register holds a result.
- `commit_rdy`  in  1  consumer accepts the commit.
- `commit_pc`  out  32  pc of the held result.
- `commit_seq_num`  out  `p_seq_num_bits`  seq_num of the held result.

## Operation
- **State:**
  - W register: `w_val`, `pc`, `seq_num`, `waddr`, `wdata`, `wen`.
  - Round-robin pointer `ptr` of width `$clog2(p_num_pipes)`.
- **Fire conditions:**
  - Commit fire: `commit_val && commit_rdy`.
  - `space = !w_val || commit_rdy`.
- **Arbitration (combinational):**
  - Scan pipes `ptr`, `ptr+1`, ... mod `p_num_pipes`; the first with `X_val` high is granted.
  - `X_rdy[i] = grant[i] && space`. At most one `X_rdy` is high per cycle.
  - `X_rdy` may depend on `X_val`. Producers must not make `X_val` depend on `X_rdy`.
- **Accept:** when `X_val[g] && X_rdy[g]`:
  - The W register loads pipe g's fields and `w_val` is set to 1.
  - `ptr` becomes `(g+1) mod p_num_pipes`.
  - With no accept, `ptr` holds.
- **Drain:** on commit fire with no accept, `w_val` is cleared to 0. Commit fire plus accept in the same cycle replaces the held result, so throughput is 1/cycle.
- **Register-file write:**
  - `rf_wen = commit fire && wen && (waddr != 0)`.
  - `rf_waddr` and `rf_wdata` come straight from the W register.
  - Writes to x0 are never emitted, but the x0 instruction still commits.
  - An instruction with `wen=0` commits with `rf_wen=0`.
- **Commit outputs:** `commit_val = w_val`. `commit_pc` and `commit_seq_num` come from the W register and stay stable while `commit_val && !commit_rdy`.
- **Ordering:** no reordering or seq_num checking is done here. Commit order equals accept order.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - `w_val`=0, `commit_val`=0, `rf_wen`=0, `ptr`=0.
  - W data fields are 0, so `commit_pc`=0, `commit_seq_num`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `X_rdy` follows its equation: high for the granted pipe, since `space`=1.
- **Latency:** a message accepted at edge t is visible on `commit_*` and `rf_*` in cycle t+1. The register write occurs in the cycle commit fires.
- **Full:** with `w_val`=1 and `commit_rdy`=0, all `X_rdy`=0 and the W register holds.
- **Empty:** with `w_val`=0, the granted pipe is accepted regardless of `commit_rdy`.
- **Simultaneous requests:** the pipe nearest `ptr` wins. Losers hold `X_val` and their message stable until accepted.
- **Pointer wrap:** from the last pipe the pointer wraps to 0.
- **Reset mid-operation:**
  - A held result is discarded with no commit and no `rf_wen`.
  - `ptr` returns to 0.
  - Operation restarts on the first edge after `rst` returns to 1.

## Test plan
- **Single result:** pipe0 sends pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1, with `commit_rdy`=1. Next cycle: `commit_val`=1, `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `commit_seq_num`=3.
- **Round-robin:** both pipes hold `X_val` continuously, pipe0 with seq 0,2,4 and pipe1 with seq 1,3,5. Commit order is 0,1,2,3,4,5, one per cycle.
- **x0 and wen=0:** send waddr=0, wdata=7, wen=1, then waddr=9, wen=0. Both commit with `commit_val`=1, and `rf_wen` stays 0 in both cycles.
- **Backpressure:** `commit_rdy`=0 for 3 cycles while pipe1 sends seq=6. `commit_seq_num` stays 6, `X_rdy`=0 throughout, and `rf_wen`=0 until `commit_rdy`=1. Then exactly one write occurs.
- **Reset mid-operation:** assert `rst`=0 while `w_val`=1 with a held seq=2. `commit_val` drops to 0 immediately with no `rf_wen`. After release, pipe0 is granted first when both pipes are valid.
- **Random:** both producers and the consumer with random 0–3 cycle delays. All messages commit exactly once, and each pipe's stream stays in order.
